snn_dist_param: RTL and testbench
=================================

SNN_DIST_PARAM -- requirements
Module: snn_dist_param

Interface
REQ-001 SHALL have parameter IMG_N, default 6, image side length; even, 6..16.
REQ-002 SHALL have parameter DW, default 8, pixel/kernel/weight width.
REQ-003 SHALL have parameter THRESH, default 16, distance below which the output is forced to 0.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  high for each input beat.
REQ-007 SHALL have port img  input  DW  pixel stream, image A then image B, raster order.
REQ-008 SHALL have port ker  input  DW  3x3 kernel, beats 0..8, raster order.
REQ-009 SHALL have port weight  input  DW  2x2 FC weights w0..w3, beats 0..3.
REQ-010 SHALL have port mode  input  1  distance select, sampled on beat 0.
REQ-011 SHALL have port out_valid  output  1  one-cycle result strobe.
REQ-012 SHALL have port out_data  output  DW+2  distance result.

Function
REQ-013 SHALL use FSM states IDLE, IN_A, IN_B, CALC, OUT: IDLE->IN_A on in_valid; IN_A->IN_B after IMG_N^2 beats; IN_B->CALC after a further IMG_N^2 beats; CALC->OUT when FC/distance done; OUT->IDLE after one cycle.
REQ-014 SHALL capture ker on beats 0..8, weight on beats 0..3, and mode on beat 0; img on all 2*IMG_N^2 beats.
REQ-015 SHALL abort a frame if in_valid deasserts before beat 2*IMG_N^2-1: no out_valid, return to IDLE, discard data.
REQ-016 SHALL ignore in_valid during CALC and OUT.
REQ-017 SHALL compute, per image, a 3x3 valid convolution (stride 1, no padding) giving an (IMG_N-2)^2 map, with sums held at 2*DW+4 bits.
REQ-018 SHALL quantise each conv sum by floor division by 9*(2^DW-1) (2295 at DW=8).
REQ-019 SHALL max-pool the quantised map into a 2x2 grid p0..p3 (raster order), each window (IMG_N-2)/2 square.
REQ-020 SHALL compute f0=p0*w0+p1*w2, f1=p0*w1+p1*w3, f2=p2*w0+p3*w2, f3=p2*w1+p3*w3, each floor-divided by 2*(2^DW-1) (510 at DW=8).
REQ-021 SHALL compute the distance D between the A and B vectors f0..f3 (|fA-fB| terms; combination per REQ-028/029) and drive out_data=(D<THRESH)?0:D.
REQ-022 SHALL assert out_valid for exactly one cycle, no more than (IMG_N-2)^2+20 cycles after the last input beat.
REQ-023 SHALL hold out_data at 0 whenever out_valid is low.
REQ-024 SHALL accept a new frame beginning the cycle after out_valid.

Reset
REQ-025 SHALL, on rst_n low at any time (including mid-input or mid-CALC), force out_valid=0, out_data=0, FSM=IDLE, and clear all counters and stored data, without waiting for clk.
REQ-026 SHALL begin a frame only on the first in_valid beat after rst_n rises.

Configuration
REQ-027 SHALL honour macro SNN_DIST_LINF_EN.
REQ-028 SHALL, with SNN_DIST_LINF_EN defined, set D=sum of |fA-fB| when mode=0 and D=max of |fA-fB| when mode=1.
REQ-029 SHALL, without SNN_DIST_LINF_EN, ignore mode and always use the L1 sum.

Verification
REQ-030 SHALL cover: IMG_N=6, img/ker/weight all 255 for both images -> out_data=0, single out_valid pulse.
REQ-031 SHALL cover: A all 255, B all 0, ker/weight all 255, mode=0 -> out_data=1020; with macro and mode=1 -> 255.
REQ-032 SHALL cover: A all 0, B all 17, ker/weight 255 -> 68; B all 3 -> 12<16 -> out_data=0.
REQ-033 SHALL cover: in_valid dropped after 40 beats -> no out_valid; the next full frame of REQ-031 -> 1020.
REQ-034 SHALL cover: rst_n low during CALC -> out_valid/out_data 0 immediately, IDLE; the following frame is correct.
REQ-035 SHALL cover: IMG_N=8 with REQ-031 stimulus -> 1020, within the 56-cycle bound.

Source files
------------

// File: rtl/snn_dist_param.sv
// Two-image SNN distance: 3x3 conv -> quantise -> 2x2 maxpool -> 2x2 FC per image, then L1 (or L-inf) distance.
// Latency: (IMG_N-2)^2+3 cycles from last input beat to the one-cycle out_valid strobe.
// No backpressure: in_valid must stay high for all 2*IMG_N^2 beats or the frame is aborted; optional macro SNN_DIST_LINF_EN.
module snn_dist_param #(
   parameter int IMG_N  = 6,
   parameter int DW     = 8,
   parameter int THRESH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] img,
   input  logic [DW-1:0] ker,
   input  logic [DW-1:0] weight,
   input  logic          mode,
   output logic          out_valid,
   output logic [DW+1:0] out_data
);

   localparam int NPIX = IMG_N * IMG_N;
   localparam int NTOT = 2 * NPIX;
   localparam int CN   = IMG_N - 2;
   localparam int HALF = CN / 2;
   localparam int CW   = $clog2(NTOT);
   localparam int PW   = $clog2(CN);
   localparam int SW   = 2 * DW + 4;
   localparam int FW   = 2 * DW + 1;
   localparam int QDIV = 9 * ((1 << DW) - 1);
   localparam int FDIV = 2 * ((1 << DW) - 1);

   typedef enum logic [2:0] {IDLE, IN_A, IN_B, CALC, OUT} state_t;
   typedef enum logic [1:0] {P_CONV, P_DRAIN, P_FC, P_DIST} phase_t;

   state_t        state;
   phase_t        phase;
   logic [CW-1:0] beat_cnt;
   logic [PW-1:0] pos_r, pos_c;

   // Captured frame data: image A occupies pix[0..NPIX-1], image B pix[NPIX..NTOT-1]
   logic [DW-1:0] pix   [NTOT];
   logic [DW-1:0] ker_r [9];
   logic [DW-1:0] w_r   [4];

   // Conv pipeline and pooling / FC state
   logic          s1_vld;
   logic [SW-1:0] s1_sum_a, s1_sum_b;
   logic [1:0]    s1_quad;
   logic [DW-1:0] pool_a [4];
   logic [DW-1:0] pool_b [4];
   logic [DW-1:0] fa [4];
   logic [DW-1:0] fb [4];

   logic          cap;
   logic          conv_issue;
   logic [CW-1:0] win_base;
   logic [1:0]    conv_quad;
   logic [SW-1:0] conv_a, conv_b;
   logic [DW-1:0] q_a, q_b;
   logic [DW-1:0] dk;
   logic [DW-1:0] dist_max;
   logic [DW+1:0] dist_l1, dist_sel, dist_res;

   function automatic logic [DW-1:0] absd(input logic [DW-1:0] x, input logic [DW-1:0] y);
      return (x > y) ? (x - y) : (y - x);
   endfunction

   function automatic logic [DW-1:0] fc_term(input logic [DW-1:0] px, input logic [DW-1:0] py,
                                             input logic [DW-1:0] wx, input logic [DW-1:0] wy);
      logic [FW-1:0] acc;
      acc = FW'(px) * FW'(wx) + FW'(py) * FW'(wy);
      return DW'(acc / FW'(FDIV));
   endfunction

   // beat_cnt is held at 0 in IDLE, so it directly indexes the current beat in all input states
   assign cap        = in_valid && (state == IDLE || state == IN_A || state == IN_B);
   assign conv_issue = (state == CALC) && (phase == P_CONV);
   assign win_base   = CW'(int'(pos_r) * IMG_N + int'(pos_c));
   assign conv_quad  = {pos_r >= PW'(HALF), pos_c >= PW'(HALF)};
   assign q_a        = DW'(s1_sum_a / SW'(QDIV));
   assign q_b        = DW'(s1_sum_b / SW'(QDIV));

   // 3x3 window MAC for both images at the current conv position
   always_comb begin
      conv_a = '0;
      conv_b = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            conv_a = conv_a + SW'(pix[CW'(int'(win_base) + i * IMG_N + j)]) * SW'(ker_r[i * 3 + j]);
            conv_b = conv_b + SW'(pix[CW'(NPIX + int'(win_base) + i * IMG_N + j)]) * SW'(ker_r[i * 3 + j]);
         end
      end
   end

   // Per-element |fA-fB|, accumulated as both a sum and a running max
   always_comb begin
      dk       = '0;
      dist_l1  = '0;
      dist_max = '0;
      for (int k = 0; k < 4; k++) begin
         dk      = absd(fa[k], fb[k]);
         dist_l1 = dist_l1 + (DW + 2)'(dk);
         if (dk > dist_max) dist_max = dk;
      end
   end

`ifdef SNN_DIST_LINF_EN
   logic mode_r;
   assign dist_sel = mode_r ? (DW + 2)'(dist_max) : dist_l1;

   // Distance-mode flag is latched from the first beat of the frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mode_r <= 1'b0;
      else if (cap && state == IDLE)
         mode_r <= mode;
   end
`else
   logic unused_mode;
   logic [DW-1:0] unused_max;
   assign unused_mode = mode;
   assign unused_max  = dist_max;
   assign dist_sel    = dist_l1;
`endif

   assign dist_res = (dist_sel < (DW + 2)'(THRESH)) ? '0 : dist_sel;

   // Frame capture: every beat stores a pixel, the first 9 a kernel tap, the first 4 a weight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NTOT; k++) pix[k] <= '0;
         for (int k = 0; k < 9; k++) ker_r[k] <= '0;
         for (int k = 0; k < 4; k++) w_r[k] <= '0;
      end else if (cap) begin
         pix[beat_cnt] <= img;
         if (beat_cnt < CW'(9)) ker_r[beat_cnt[3:0]] <= ker;
         if (beat_cnt < CW'(4)) w_r[beat_cnt[1:0]] <= weight;
      end
   end

   // Conv register stage, quantise + max-pool stage, then the FC layer; pools restart every frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld   <= 1'b0;
         s1_sum_a <= '0;
         s1_sum_b <= '0;
         s1_quad  <= '0;
         for (int k = 0; k < 4; k++) begin
            pool_a[k] <= '0;
            pool_b[k] <= '0;
            fa[k]     <= '0;
            fb[k]     <= '0;
         end
      end else if (state != CALC) begin
         s1_vld <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            pool_a[k] <= '0;
            pool_b[k] <= '0;
         end
      end else begin
         s1_vld <= conv_issue;
         if (conv_issue) begin
            s1_sum_a <= conv_a;
            s1_sum_b <= conv_b;
            s1_quad  <= conv_quad;
         end
         if (s1_vld) begin
            if (q_a > pool_a[s1_quad]) pool_a[s1_quad] <= q_a;
            if (q_b > pool_b[s1_quad]) pool_b[s1_quad] <= q_b;
         end
         if (phase == P_FC) begin
            fa[0] <= fc_term(pool_a[0], pool_a[1], w_r[0], w_r[2]);
            fa[1] <= fc_term(pool_a[0], pool_a[1], w_r[1], w_r[3]);
            fa[2] <= fc_term(pool_a[2], pool_a[3], w_r[0], w_r[2]);
            fa[3] <= fc_term(pool_a[2], pool_a[3], w_r[1], w_r[3]);
            fb[0] <= fc_term(pool_b[0], pool_b[1], w_r[0], w_r[2]);
            fb[1] <= fc_term(pool_b[0], pool_b[1], w_r[1], w_r[3]);
            fb[2] <= fc_term(pool_b[2], pool_b[3], w_r[0], w_r[2]);
            fb[3] <= fc_term(pool_b[2], pool_b[3], w_r[1], w_r[3]);
         end
      end
   end

   // Frame sequencer: input beats, conv sweep, FC/distance phases, one-cycle registered result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         phase     <= P_CONV;
         beat_cnt  <= '0;
         pos_r     <= '0;
         pos_c     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state    <= IN_A;
                  beat_cnt <= CW'(1);
               end
            end
            IN_A: begin
               if (!in_valid) begin
                  state    <= IDLE;
                  beat_cnt <= '0;
               end else begin
                  beat_cnt <= beat_cnt + CW'(1);
                  if (beat_cnt == CW'(NPIX - 1)) state <= IN_B;
               end
            end
            IN_B: begin
               if (!in_valid) begin
                  state    <= IDLE;
                  beat_cnt <= '0;
               end else if (beat_cnt == CW'(NTOT - 1)) begin
                  state    <= CALC;
                  phase    <= P_CONV;
                  beat_cnt <= '0;
                  pos_r    <= '0;
                  pos_c    <= '0;
               end else begin
                  beat_cnt <= beat_cnt + CW'(1);
               end
            end
            CALC: begin
               case (phase)
                  P_CONV: begin
                     if (pos_c == PW'(CN - 1)) begin
                        pos_c <= '0;
                        if (pos_r == PW'(CN - 1))
                           phase <= P_DRAIN;
                        else
                           pos_r <= pos_r + PW'(1);
                     end else begin
                        pos_c <= pos_c + PW'(1);
                     end
                  end
                  P_DRAIN: phase <= P_FC;
                  P_FC:    phase <= P_DIST;
                  P_DIST: begin
                     state     <= OUT;
                     out_valid <= 1'b1;
                     out_data  <= dist_res;
                  end
                  default: phase <= P_CONV;
               endcase
            end
            OUT: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               out_data  <= '0;
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               out_data  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snn_dist_param.sv
// Directed bench for snn_dist_param at IMG_N=6 and IMG_N=8.
// Expected values are hand-computed from the conv/pool/FC/distance definitions.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_snn_dist_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid6, in_valid8, mode;
   logic [7:0] img, ker, weight;
   logic       ov6, ov8;
   logic [9:0] od6, od8;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   int pulses, lat, data, idle_bad;

   always #5 clk = ~clk;

   snn_dist_param #(.IMG_N(6), .DW(8), .THRESH(16)) dut6 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .img(img), .ker(ker),
      .weight(weight), .mode(mode), .out_valid(ov6), .out_data(od6)
   );

   snn_dist_param #(.IMG_N(8), .DW(8), .THRESH(16)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .img(img), .ker(ker),
      .weight(weight), .mode(mode), .out_valid(ov8), .out_data(od8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Image A pixel is a_val on rows >= a_split, else 0; image B is uniform b_val.
   task automatic send(input int sel, input int n, input logic [7:0] a_val, input int a_split,
                       input logic [7:0] b_val, input logic [7:0] k_val,
                       input logic [7:0] w0, input logic [7:0] w1,
                       input logic [7:0] w2, input logic [7:0] w3,
                       input logic m, input int nbeats);
      int npix;
      npix = n * n;
      for (int b = 0; b < nbeats; b++) begin
         @(negedge clk);
         if (sel == 0) in_valid6 = 1'b1; else in_valid8 = 1'b1;
         if (b < npix) img = ((b / n) >= a_split) ? a_val : 8'd0;
         else          img = b_val;
         ker = (b < 9) ? k_val : 8'(b * 7);
         case (b)
            0:       weight = w0;
            1:       weight = w1;
            2:       weight = w2;
            3:       weight = w3;
            default: weight = 8'(b * 13);
         endcase
         mode = (b == 0) ? m : ~m;
      end
      @(negedge clk);
      in_valid6 = 1'b0;
      in_valid8 = 1'b0;
      img = 8'd0; ker = 8'd0; weight = 8'd0; mode = 1'b0;
   endtask

   // Observe the output for maxc cycles: pulse count, first-pulse latency, data, idle-data violations.
   task automatic collect(input int sel, input int maxc, output int np, output int lt,
                          output int dt, output int ib);
      logic       v;
      logic [9:0] d;
      np = 0; lt = -1; dt = -1; ib = 0;
      for (int c = 0; c < maxc; c++) begin
         v = (sel == 0) ? ov6 : ov8;
         d = (sel == 0) ? od6 : od8;
         if (v === 1'b1) begin
            np++;
            if (lt < 0) lt = c;
            dt = int'(d);
         end else if (d !== 10'd0) begin
            ib++;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid6 = 1'b0; in_valid8 = 1'b0;
      img = 8'd0; ker = 8'd0; weight = 8'd0; mode = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ov6", ov6, 0);
      chk("rst_od6", od6, 0);
      chk("rst_ov8", ov8, 0);
      chk("rst_od8", od8, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // identical all-255 images -> distance 0
      send(0, 6, 8'd255, 0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 72);
      collect(0, 45, pulses, lat, data, idle_bad);
      chk("same_pulses", pulses, 1);
      chk("same_data", data, 0);
      chk("same_latency", (lat >= 0 && lat <= 36), 1);
      chk("same_idle_zero", idle_bad, 0);

      // A=255, B=0 -> every f differs by 255
      send(0, 6, 8'd255, 0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 72);
      collect(0, 45, pulses, lat, data, idle_bad);
      chk("l1_max_data", data, 1020);

      send(0, 6, 8'd255, 0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 72);
      collect(0, 45, pulses, lat, data, idle_bad);
`ifdef SNN_DIST_LINF_EN
      chk("mode1_data", data, 255);
`else
      chk("mode1_data", data, 1020);
`endif

      // A=0, B=17 -> 4*17
      send(0, 6, 8'd0, 0, 8'd17, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 72);
      collect(0, 45, pulses, lat, data, idle_bad);
      chk("b17_data", data, 68);

      // A=0, B=3 -> 12 is below threshold
      send(0, 6, 8'd0, 0, 8'd3, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 72);
      collect(0, 45, pulses, lat, data, idle_bad);
      chk("b3_thresh_pulses", pulses, 1);
      chk("b3_thresh_data", data, 0);

      // A bottom half 255: pools 85,85,255,255; w=(255,0,0,0) -> f=(42,0,127,0)
      send(0, 6, 8'd255, 3, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 1'b0, 72);
      collect(0, 45, pulses, lat, data, idle_bad);
      chk("split_l1_data", data, 169);
      send(0, 6, 8'd255, 3, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 1'b1, 72);
      collect(0, 45, pulses, lat, data, idle_bad);
`ifdef SNN_DIST_LINF_EN
      chk("split_mode1_data", data, 127);
`else
      chk("split_mode1_data", data, 169);
`endif

      // aborted frame after 40 beats, then a full frame
      send(0, 6, 8'd255, 0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 40);
      collect(0, 45, pulses, lat, data, idle_bad);
      chk("abort_pulses", pulses, 0);
      send(0, 6, 8'd255, 0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 72);
      collect(0, 45, pulses, lat, data, idle_bad);
      chk("post_abort_data", data, 1020);

      // reset during CALC
      send(0, 6, 8'd255, 0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 72);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("calc_rst_ov", ov6, 0);
      chk("calc_rst_od", od6, 0);
      @(negedge clk);
      rst_n = 1'b1;
      collect(0, 45, pulses, lat, data, idle_bad);
      chk("calc_rst_pulses", pulses, 0);
      send(0, 6, 8'd255, 0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 72);
      collect(0, 45, pulses, lat, data, idle_bad);
      chk("post_calc_rst_data", data, 1020);

      // reset while out_valid is high must clear outputs without a clock edge
      send(0, 6, 8'd255, 0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 72);
      for (int c = 0; c < 45; c++) begin
         if (ov6 === 1'b1) break;
         @(negedge clk);
      end
      chk("out_before_rst_data", od6, 1020);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_ov", ov6, 0);
      chk("async_rst_od", od6, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send(0, 6, 8'd0, 0, 8'd17, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 72);
      collect(0, 45, pulses, lat, data, idle_bad);
      chk("post_async_rst_data", data, 68);

      // IMG_N=8 instance
      send(1, 8, 8'd255, 0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 128);
      collect(1, 65, pulses, lat, data, idle_bad);
      chk("n8_pulses", pulses, 1);
      chk("n8_data", data, 1020);
      chk("n8_latency", (lat >= 0 && lat <= 56), 1);
      chk("n8_idle_zero", idle_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
